// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NREQ producers
// Optional stall counter output is enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  output logic [OW-1:0]         owner,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]           stall_cnt,
`endif
  output logic                  busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]       state;
  logic [BW-1:0]    burst_cnt;
  logic [OW-1:0]    next_owner;
  logic             req_own;
  logic             xfer;
  logic [WIDTH-1:0] lane;

  assign req_own = req[owner];
  assign lane    = req_data[int'(owner)*WIDTH +: WIDTH];
  assign xfer    = (state == S_OWN) && req_own && !fifo_full;
  assign busy    = (state == S_OWN);

  // Scan from farthest to nearest so the nearest requester after owner wins.
  always_comb begin
    next_owner = owner;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(owner) + k) % NREQ])
        next_owner = OW'((int'(owner) + k) % NREQ);
    end
  end

  always_comb begin
    gnt          = '0;
    fifo_wr_en   = xfer;
    fifo_wr_data = (state == S_OWN) ? lane : '0;
    if (xfer)
      gnt[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_OWN;
            owner     <= next_owner;
            burst_cnt <= '0;
          end
        end
        default: begin
          // Stalls (req held, FIFO full) fall through every branch and keep the count.
          if (!req_own) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
          end else if (xfer) begin
            if (burst_cnt == BW'(BURST - 1)) begin
              state     <= S_IDLE;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if ((state == S_OWN) && req_own && fifo_full && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized self-checking bench for fifo_wr_arbiter
// Build with FIFO_ARB_STATS_EN defined to also check stall_cnt.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic [1:0]            owner;
  logic                  busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]           stall_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .owner(owner),
`ifdef FIFO_ARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Producers: requester i offers base[i]+cnt[i] while rem[i] words remain.
  int          rem  [NREQ];
  int          cnt  [NREQ];
  logic [7:0]  base [NREQ];
  logic [NREQ-1:0] drop;

  // Reference model of the arbiter in terms of tenure: who owns, words used.
  bit m_busy;
  int m_owner;
  int m_used;
  int m_stalls;

  int cyc = 0;
  int log_cyc[$];
  int log_who[$];
  int log_dat[$];
  logic [NREQ-1:0] obs_gnt;
  logic obs_wr, obs_busy;
  int obs_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] word_of(input int i);
    return base[i] + 8'(cnt[i]);
  endfunction

  task automatic model_step(input logic r, input logic [NREQ-1:0] rq, input logic full);
    if (r) begin
      m_busy = 0; m_owner = NREQ - 1; m_used = 0; m_stalls = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (rq[(m_owner + k) % NREQ]) begin
          m_owner = (m_owner + k) % NREQ;
          m_busy = 1;
          m_used = 0;
          break;
        end
      end
    end else if (!rq[m_owner]) begin
      m_busy = 0;
    end else if (full) begin
      if (m_stalls < 65535) m_stalls++;
    end else begin
      m_used++;
      if (m_used == BURST) m_busy = 0;
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model and producers.
  task automatic tick();
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] exp_gnt;
    logic [7:0] exp_dat;
    bit exp_x;
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = (rem[i] > 0) && !drop[i];
      req_data[i*WIDTH +: WIDTH] = word_of(i);
    end
    req = rq;
    #4;
    exp_x   = m_busy && rq[m_owner] && !fifo_full;
    exp_gnt = exp_x ? NREQ'(1) << m_owner : '0;
    exp_dat = m_busy ? word_of(m_owner) : 8'h00;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("wr_en", 32'(fifo_wr_en), 32'(exp_x));
    check("wr_data", 32'(fifo_wr_data), 32'(exp_dat));
    check("busy", 32'(busy), 32'(m_busy));
    check("owner", 32'(owner), 32'(m_owner));
`ifdef FIFO_ARB_STATS_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
    obs_gnt = gnt; obs_wr = fifo_wr_en; obs_busy = busy; obs_owner = int'(owner);
    if (fifo_wr_en) begin
      int who = -1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) who = i;
      log_cyc.push_back(cyc);
      log_who.push_back(who);
      log_dat.push_back(int'(fifo_wr_data));
    end
    for (int i = 0; i < NREQ; i++)
      if (gnt[i] && rem[i] > 0) begin cnt[i]++; rem[i]--; end
    model_step(rst, rq, fifo_full);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; cnt[i] = 0; base[i] = 8'h00; end
    drop = '0; fifo_full = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    log_cyc.delete(); log_who.delete(); log_dat.delete();
  endtask

  initial begin
    int rel, stall_left, rc;
    bit stalled, did_rst;

    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; cnt[i] = 0; base[i] = 8'h00; end
    drop = '0; fifo_full = 1'b0; rst = 1'b1; req = '0; req_data = '0;
    m_busy = 0; m_owner = NREQ - 1; m_used = 0; m_stalls = 0;
    @(posedge clk); #1;

    // Reset held 3 cycles with all requests high; first grant goes to 0.
    for (int i = 0; i < NREQ; i++) rem[i] = 100;
    for (int r = 0; r < 3; r++) begin
      tick();
      check("rst_gnt", 32'(obs_gnt), 0);
      check("rst_wr", 32'(obs_wr), 0);
      check("rst_busy", 32'(obs_busy), 0);
      check("rst_owner", 32'(obs_owner), 3);
    end
    rst = 1'b0;
    rel = cyc;
    for (int t = 0; t < 3; t++) tick();
    check("rst_nwr", 32'(log_who.size() > 0), 1);
    if (log_who.size() > 0) begin
      check("rst_first_who", 32'(log_who[0]), 0);
      check("rst_first_cyc", 32'(log_cyc[0]), 32'(rel + 1));
    end

    // Single requester, 6 words: 4-word burst, one bubble, then 2 words.
    clean();
    base[2] = 8'h10; rem[2] = 6;
    for (int t = 0; t < 12; t++) tick();
    check("single_n", 32'(log_dat.size()), 6);
    if (log_dat.size() == 6)
      for (int k = 0; k < 6; k++) begin
        check("single_dat", 32'(log_dat[k]), 32'(8'h10 + k));
        check("single_cyc", 32'(log_cyc[k]), 32'(log_cyc[0] + k + (k >= 4 ? 1 : 0)));
      end

    // All four requesting, FIFO never full: 0,1,2,3,0 with one bubble between owners.
    clean();
    for (int i = 0; i < NREQ; i++) begin base[i] = 8'(i * 64); rem[i] = 8; end
    for (int t = 0; t < 26; t++) tick();
    check("rr_n", 32'(log_who.size() >= 20), 1);
    if (log_who.size() >= 20)
      for (int k = 0; k < 20; k++) begin
        check("rr_who", 32'(log_who[k]), 32'((k / 4) % 4));
        check("rr_cyc", 32'(log_cyc[k]), 32'(log_cyc[0] + k + k / 4));
        if (k < 4) check("rr_dat0", 32'(log_dat[k]), 32'(k));
      end

    // Stall of 3 cycles after the 2nd write of requester 1.
    clean();
    base[1] = 8'h20; rem[1] = 4; stall_left = 0; stalled = 0;
    for (int t = 0; t < 14; t++) begin
      fifo_full = (stall_left > 0);
      tick();
      if (stall_left > 0) begin
        check("stall_wr", 32'(obs_wr), 0);
        check("stall_gnt", 32'(obs_gnt), 0);
        check("stall_busy", 32'(obs_busy), 1);
        stall_left--;
      end
      if (log_cyc.size() == 2 && !stalled) begin stall_left = 3; stalled = 1; end
    end
    fifo_full = 1'b0;
    check("stall_n", 32'(log_cyc.size()), 4);
    if (log_cyc.size() == 4) begin
      check("stall_gap", 32'(log_cyc[2] - log_cyc[1]), 4);
      check("stall_tail", 32'(log_cyc[3] - log_cyc[2]), 1);
    end
`ifdef FIFO_ARB_STATS_EN
    check("stall_total", 32'(stall_cnt), 3);
`endif

    // Early release: requester 0 leaves after 2 words, requester 3 follows.
    clean();
    base[0] = 8'h30; rem[0] = 2; base[3] = 8'h40; rem[3] = 3;
    for (int t = 0; t < 10; t++) tick();
    check("early_n", 32'(log_who.size()), 5);
    if (log_who.size() == 5) begin
      check("early_who1", 32'(log_who[1]), 0);
      check("early_who2", 32'(log_who[2]), 3);
      check("early_gap", 32'(log_cyc[2] - log_cyc[1]), 3);
      check("early_dat", 32'(log_dat[2]), 32'h40);
    end

    // Reset during requester 2's 3rd word; requester 1 wins afterwards.
    clean();
    base[2] = 8'h50; rem[2] = 8; did_rst = 0; rc = 0;
    for (int t = 0; t < 12; t++) begin
      if (log_cyc.size() == 2 && !did_rst) begin rst = 1'b1; did_rst = 1; rc = cyc; end
      tick();
      if (rst) begin rst = 1'b0; base[1] = 8'h60; rem[1] = 4; end
    end
    check("mid_rst_n", 32'(log_who.size() >= 4), 1);
    if (log_who.size() >= 4) begin
      check("mid_rst_who2", 32'(log_who[2]), 2);
      check("mid_rst_who3", 32'(log_who[3]), 1);
      check("mid_rst_cyc", 32'(log_cyc[3]), 32'(rc + 2));
    end

    // Randomized traffic with stalls, drops and occasional resets.
    clean();
    for (int t = 0; t < 2000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
          rem[i] = $urandom_range(1, 10);
          base[i] = 8'($urandom);
        end
        drop[i] = ($urandom_range(0, 9) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
